// File: rtl/color_sensor_sequencer.sv
// TCS3200 measurement sequencer: warms the sensor up, then counts edges through the
// R, G, B and clear filters in turn and publishes the four raw counts with a done pulse.
module color_sensor_sequencer #(
    parameter int WARMUP_CYC = 50000,
    parameter int SETTLE_CYC = 1000,
    parameter int WINDOW_CYC = 5000000,
    parameter int CNT_W      = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sensor_out,
    output logic [1:0]       s0_s1,
    output logic [1:0]       s2_s3,
    output logic             led_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE, WARMUP, SELECT, SETTLE, COUNT, STORE, DONE
    } state_t;

    typedef enum logic [1:0] {CH_R, CH_G, CH_B, CH_C} ch_t;

    localparam logic [31:0] WARMUP_LAST = WARMUP_CYC - 1;
    localparam logic [31:0] SETTLE_LAST = SETTLE_CYC - 1;
    localparam logic [31:0] WINDOW_LAST = WINDOW_CYC - 1;

    state_t           state, state_n;
    ch_t              ch, ch_n;
    logic [31:0]      tcnt;
    logic             sens_p0, sens_p1, sens_p2;
    logic             edge_pulse;
    logic [CNT_W-1:0] work_cnt;
    logic             ovf_run;
    logic [CNT_W-1:0] red_sh, green_sh, blue_sh;

    function automatic logic [1:0] filter_code(input ch_t c);
        case (c)
            CH_R:    filter_code = 2'b00;
            CH_G:    filter_code = 2'b11;
            CH_B:    filter_code = 2'b01;
            default: filter_code = 2'b10;
        endcase
    endfunction

    function automatic ch_t next_ch(input ch_t c);
        case (c)
            CH_R:    next_ch = CH_G;
            CH_G:    next_ch = CH_B;
            default: next_ch = CH_C;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: previous value for the rising-edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sens_p0 <= 1'b0;
            sens_p1 <= 1'b0;
            sens_p2 <= 1'b0;
        end else begin
            sens_p0 <= sensor_out;
            sens_p1 <= sens_p0;
            sens_p2 <= sens_p1;
        end
    end

    assign edge_pulse = sens_p1 & ~sens_p2;

    always_comb begin
        state_n = state;
        ch_n    = ch;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = WARMUP;
                    ch_n    = CH_R;
                end
            end
            WARMUP: if (tcnt == WARMUP_LAST) state_n = SELECT;
            SELECT: state_n = SETTLE;
            SETTLE: if (tcnt == SETTLE_LAST) state_n = COUNT;
            COUNT:  if (tcnt == WINDOW_LAST) state_n = STORE;
            STORE: begin
                if (ch == CH_C) begin
                    state_n = DONE;
                end else begin
                    state_n = SELECT;
                    ch_n    = next_ch(ch);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE)
            state_n = IDLE;
    end

    // The phase timer restarts on every state change, so each phase counts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ch    <= CH_R;
            tcnt  <= 32'd0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            tcnt  <= (state_n != state) ? 32'd0 : tcnt + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_cnt <= '0;
            ovf_run  <= 1'b0;
            red_sh   <= '0;
            green_sh <= '0;
            blue_sh  <= '0;
        end else begin
            if (state == IDLE && state_n == WARMUP)
                ovf_run <= 1'b0;
            if (state == SELECT) begin
                work_cnt <= '0;
            end else if (state == COUNT && edge_pulse) begin
                if (&work_cnt)
                    ovf_run <= 1'b1;
                else
                    work_cnt <= work_cnt + 1'b1;
            end
            if (state == STORE) begin
                case (ch)
                    CH_R:    red_sh   <= work_cnt;
                    CH_G:    green_sh <= work_cnt;
                    CH_B:    blue_sh  <= work_cnt;
                    default: ;
                endcase
            end
        end
    end

    // Results load on the edge into DONE so they change together with the done pulse;
    // the clear channel goes straight from the working counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_cnt   <= '0;
            green_cnt <= '0;
            blue_cnt  <= '0;
            clear_cnt <= '0;
            overflow  <= 1'b0;
            s2_s3     <= 2'b00;
        end else begin
            if (state == STORE && state_n == DONE) begin
                red_cnt   <= red_sh;
                green_cnt <= green_sh;
                blue_cnt  <= blue_sh;
                clear_cnt <= work_cnt;
                overflow  <= ovf_run;
            end
            if (state_n == IDLE)
                s2_s3 <= 2'b00;
            else if (state_n == SELECT)
                s2_s3 <= filter_code(ch_n);
        end
    end

    assign busy   = (state != IDLE);
    assign led_en = busy;
    assign s0_s1  = busy ? 2'b10 : 2'b00;
    assign done   = (state == DONE);

endmodule

// File: tb/tb_color_sensor_sequencer.sv
// Directed bench for color_sensor_sequencer; expected results are queued at start and
// compared when done pulses.
module tb_color_sensor_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0, sensor_a = 1'b0;
    logic [1:0]  s0_s1_a, s2_s3_a;
    logic        led_en_a, busy_a, done_a, ovf_a;
    logic [20:0] red_a, green_a, blue_a, clear_a;

    logic        start_b = 1'b0, abort_b = 1'b0, sensor_b = 1'b0;
    logic [1:0]  s0_s1_b, s2_s3_b;
    logic        led_en_b, busy_b, done_b, ovf_b;
    logic [2:0]  red_b, green_b, blue_b, clear_b;

    color_sensor_sequencer #(.WARMUP_CYC(4), .SETTLE_CYC(2), .WINDOW_CYC(10), .CNT_W(21)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .sensor_out(sensor_a),
        .s0_s1(s0_s1_a), .s2_s3(s2_s3_a), .led_en(led_en_a), .busy(busy_a), .done(done_a),
        .red_cnt(red_a), .green_cnt(green_a), .blue_cnt(blue_a), .clear_cnt(clear_a),
        .overflow(ovf_a)
    );

    color_sensor_sequencer #(.WARMUP_CYC(4), .SETTLE_CYC(2), .WINDOW_CYC(20), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .sensor_out(sensor_b),
        .s0_s1(s0_s1_b), .s2_s3(s2_s3_b), .led_en(led_en_b), .busy(busy_b), .done(done_b),
        .red_cnt(red_b), .green_cnt(green_b), .blue_cnt(blue_b), .clear_cnt(clear_b),
        .overflow(ovf_b)
    );

    typedef struct {
        logic [20:0] r, g, b, c;
        logic        ovf;
    } exp_t;

    exp_t       qa[$], qb[$];
    exp_t       ea, eb;
    int         checks = 0, errors = 0;
    int         done_cnt_a = 0, done_cnt_b = 0, exp_dones_a = 0, exp_dones_b = 0;
    int         mode_a = 0, mode_b = 0;
    logic [1:0] s23_log[$];
    logic [1:0] s23_last = 2'b00;

    function automatic exp_t mk(input int r, input int g, input int b, input int c, input logic o);
        exp_t e;
        e.r = 21'(r); e.g = 21'(g); e.b = 21'(b); e.c = 21'(c); e.ovf = o;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard both DUTs, log s2_s3 changes, then drive the sensor inputs
    task automatic tick();
        @(negedge clk);
        if (done_a) begin
            done_cnt_a++;
            if (qa.size() == 0) begin
                check("unexpected_done_a", {31'd0, done_a}, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("red_a", {11'd0, red_a}, {11'd0, ea.r});
                check("green_a", {11'd0, green_a}, {11'd0, ea.g});
                check("blue_a", {11'd0, blue_a}, {11'd0, ea.b});
                check("clear_a", {11'd0, clear_a}, {11'd0, ea.c});
                check("ovf_a", {31'd0, ovf_a}, {31'd0, ea.ovf});
                check("busy_in_done_a", {31'd0, busy_a}, 32'd1);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            if (qb.size() == 0) begin
                check("unexpected_done_b", {31'd0, done_b}, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("red_b", {29'd0, red_b}, {11'd0, eb.r});
                check("green_b", {29'd0, green_b}, {11'd0, eb.g});
                check("blue_b", {29'd0, blue_b}, {11'd0, eb.b});
                check("clear_b", {29'd0, clear_b}, {11'd0, eb.c});
                check("ovf_b", {31'd0, ovf_b}, {31'd0, eb.ovf});
            end
        end
        if (s2_s3_a != s23_last) begin
            s23_log.push_back(s2_s3_a);
            s23_last = s2_s3_a;
        end
        case (mode_a)
            1:       sensor_a = ~sensor_a;
            2:       sensor_a = (s2_s3_a == 2'b11) ? ~sensor_a : 1'b0;
            default: sensor_a = 1'b0;
        endcase
        sensor_b = (mode_b == 1) ? ~sensor_b : 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag, input int budget);
        int k = 0;
        while ((qa.size() != 0 || busy_a) && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_completed"}, {31'd0, (qa.size() == 0 && !busy_a)}, 32'd1);
    endtask

    task automatic wait_idle_b(input string tag, input int budget);
        int k = 0;
        while ((qb.size() != 0 || busy_b) && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_completed"}, {31'd0, (qb.size() == 0 && !busy_b)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b1;
        tick();
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_led", {31'd0, led_en_a}, 32'd0);
        check("rst_s0s1", {30'd0, s0_s1_a}, 32'd0);
        check("rst_s2s3", {30'd0, s2_s3_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_counts_a", {11'd0, red_a | green_a | blue_a | clear_a}, 32'd0);
        check("rst_ovf_b", {31'd0, ovf_b}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // Full run, sensor toggling every clock
        mode_a = 1;
        cyc(2);
        s23_log.delete();
        qa.push_back(mk(5, 5, 5, 5, 1'b0));
        exp_dones_a++;
        pulse_start_a();
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        check("led_after_start", {31'd0, led_en_a}, 32'd1);
        check("s0s1_busy", {30'd0, s0_s1_a}, 32'd2);
        cyc(59);
        check("done_not_early", {31'd0, done_a}, 32'd0);
        cyc(1);
        check("done_at_61", {31'd0, done_a}, 32'd1);
        cyc(1);
        check("done_one_cycle", {31'd0, done_a}, 32'd0);
        check("busy_after_done", {31'd0, busy_a}, 32'd0);
        check("s2s3_idle", {30'd0, s2_s3_a}, 32'd0);
        check("s2s3_seq_len", s23_log.size(), 32'd4);
        if (s23_log.size() == 4) begin
            check("s2s3_seq_g", {30'd0, s23_log[0]}, 32'd3);
            check("s2s3_seq_b", {30'd0, s23_log[1]}, 32'd1);
            check("s2s3_seq_c", {30'd0, s23_log[2]}, 32'd2);
            check("s2s3_seq_off", {30'd0, s23_log[3]}, 32'd0);
        end

        // Sensor active only while the green filter is selected
        mode_a = 2;
        cyc(2);
        qa.push_back(mk(0, 5, 0, 0, 1'b0));
        exp_dones_a++;
        pulse_start_a();
        wait_idle_a("green_only", 200);
        mode_a = 0;

        // Abort during the blue settle phase
        mode_a = 1;
        pulse_start_a();
        k = 0;
        while (s2_s3_a != 2'b01 && k < 100) begin
            tick();
            k++;
        end
        check("reach_blue", {30'd0, s2_s3_a}, 32'd1);
        cyc(2);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_s2s3", {30'd0, s2_s3_a}, 32'd0);
        cyc(80);
        check("abort_green_kept", {11'd0, green_a}, 32'd5);
        check("abort_red_kept", {11'd0, red_a}, 32'd0);
        check("abort_no_done", done_cnt_a, exp_dones_a);

        // start while busy, then start+abort together in IDLE
        qa.push_back(mk(5, 5, 5, 5, 1'b0));
        exp_dones_a++;
        pulse_start_a();
        cyc(10);
        pulse_start_a();
        cyc(20);
        pulse_start_a();
        wait_idle_a("restart_ignored", 200);
        cyc(5);
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("start_abort_idle", {31'd0, busy_a}, 32'd0);
        cyc(80);
        check("one_done_per_start", done_cnt_a, exp_dones_a);

        // Asynchronous reset in the middle of the red counting window
        pulse_start_a();
        cyc(10);
        check("in_count_busy", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_a}, 32'd0);
        check("arst_led", {31'd0, led_en_a}, 32'd0);
        check("arst_s0s1", {30'd0, s0_s1_a}, 32'd0);
        check("arst_s2s3", {30'd0, s2_s3_a}, 32'd0);
        check("arst_done", {31'd0, done_a}, 32'd0);
        check("arst_red", {11'd0, red_a}, 32'd0);
        check("arst_clear", {11'd0, clear_a}, 32'd0);
        check("arst_ovf", {31'd0, ovf_a}, 32'd0);
        tick();
        rst = 1'b0;
        mode_a = 0;
        cyc(3);
        check("post_rst_idle", {31'd0, busy_a}, 32'd0);

        // Narrow counters: saturation then a clean run clears overflow
        mode_b = 1;
        cyc(2);
        qb.push_back(mk(7, 7, 7, 7, 1'b1));
        exp_dones_b++;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_idle_b("saturate", 300);
        mode_b = 0;
        cyc(6);
        qb.push_back(mk(0, 0, 0, 0, 1'b0));
        exp_dones_b++;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_idle_b("ovf_cleared", 300);

        check("total_dones_a", done_cnt_a, exp_dones_a);
        check("total_dones_b", done_cnt_b, exp_dones_b);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
